// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_rx_pkg
// Brief   : Shared state encoding, prescale constants and widths for the UART receive controller.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam int C_PRESCALE_8  = 8;
    localparam int C_PRESCALE_16 = 16;
    localparam int C_PRESCALE_32 = 32;
    localparam int C_DATA_WIDTH  = 8;
    localparam int C_BIT_CNT_W   = 4;

    // Any ratio other than the three supported ones falls back to 8.
    function automatic logic [5:0] legal_prescale(input logic [5:0] p);
        case (p)
            6'(C_PRESCALE_16): return 6'(C_PRESCALE_16);
            6'(C_PRESCALE_32): return 6'(C_PRESCALE_32);
            default:           return 6'(C_PRESCALE_8);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_bit_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : edge_bit_counter
// Brief   : Oversampling edge counter with per-bit wrap and bit counter; clear has priority over enable.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic                   i_clr,
    input  logic [CNT_W-1:0]       i_prescale,
    output logic [CNT_W-1:0]       o_edge_cnt,
    output logic [C_BIT_CNT_W-1:0] o_bit_cnt,
    output logic                   o_bit_end
);

    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic [C_BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    assign o_bit_end = (edge_cnt_q == i_prescale - CNT_W'(1));

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        if (i_clr) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (i_en) begin
            if (o_bit_end) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + C_BIT_CNT_W'(1);
            end else begin
                edge_cnt_d = edge_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign o_edge_cnt = edge_cnt_q;
    assign o_bit_cnt  = bit_cnt_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : uart_rx_fsm
// Brief   : UART receive frame controller driving sampler/checker strobes; parity via UART_RX_PARITY_EN.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int CNT_W      = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_in,
    input  logic [5:0]             prescale,
    input  logic                   par_en,
    input  logic                   par_typ,
    input  logic                   strt_glitch,
    input  logic                   par_err,
    input  logic                   stp_err,
    output logic                   dat_samp_en,
    output logic                   strt_chk_en,
    output logic                   deser_en,
    output logic                   par_chk_en,
    output logic                   stp_chk_en,
    output logic                   data_valid,
    output logic [CNT_W-1:0]       edge_cnt,
    output logic [C_BIT_CNT_W-1:0] bit_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             dat_samp_en_q, dat_samp_en_d;
    logic             strt_chk_en_q, strt_chk_en_d;
    logic             deser_en_q, deser_en_d;
    logic             par_chk_en_q, par_chk_en_d;
    logic             stp_chk_en_q, stp_chk_en_d;
    logic             data_valid_q, data_valid_d;
    logic             w_cnt_en, w_cnt_clr, w_bit_end, w_frame_start, w_pre_strobe;
    logic             w_unused;

`ifdef UART_RX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_err_mem_q, par_err_mem_d;
    assign w_unused = par_typ;
`else
    assign w_unused = ^{par_typ, par_en, par_err};
`endif

    edge_bit_counter #(
        .CNT_W (CNT_W)
    ) u_edge_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_cnt_en),
        .i_clr      (w_cnt_clr),
        .i_prescale (presc_q),
        .o_edge_cnt (edge_cnt),
        .o_bit_cnt  (bit_cnt),
        .o_bit_end  (w_bit_end)
    );

    // Strobes are registered, so they are launched one count early to land on P-2.
    assign w_pre_strobe = (edge_cnt == presc_q - CNT_W'(3));
    assign w_cnt_en     = (state_q != IDLE) && (state_q != DONE);

    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        w_frame_start  = 1'b0;
        strt_chk_en_d  = 1'b0;
        deser_en_d     = 1'b0;
        par_chk_en_d   = 1'b0;
        stp_chk_en_d   = 1'b0;
        data_valid_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_d       = par_en_q;
        par_err_mem_d  = par_err_mem_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_in) begin
                    state_d       = START;
                    w_frame_start = 1'b1;
                end
            end
            START: begin
                strt_chk_en_d = w_pre_strobe;
                if (w_bit_end) state_d = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                deser_en_d = w_pre_strobe;
                if (w_bit_end && (bit_cnt == C_BIT_CNT_W'(DATA_WIDTH))) begin
`ifdef UART_RX_PARITY_EN
                    state_d = par_en_q ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                par_chk_en_d = w_pre_strobe;
                if (w_bit_end) begin
                    state_d       = STOP;
                    par_err_mem_d = par_err_mem_q | par_err;
                end
            end
`endif
            STOP: begin
                stp_chk_en_d = w_pre_strobe;
                if (w_bit_end) begin
                    state_d = DONE;
`ifdef UART_RX_PARITY_EN
                    data_valid_d = !stp_err && !par_err_mem_q;
`else
                    data_valid_d = !stp_err;
`endif
                end
            end
            DONE: begin
                if (!rx_in) begin
                    state_d       = START;
                    w_frame_start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_frame_start) begin
            presc_d = CNT_W'(legal_prescale(prescale));
`ifdef UART_RX_PARITY_EN
            par_en_d      = par_en;
            par_err_mem_d = 1'b0;
`endif
        end

        dat_samp_en_d = (state_d != IDLE) && (state_d != DONE);
        w_cnt_clr     = (state_q == IDLE) || (state_q == DONE) ||
                        (state_d == IDLE) || (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            presc_q       <= CNT_W'(C_PRESCALE_8);
            dat_samp_en_q <= 1'b0;
            strt_chk_en_q <= 1'b0;
            deser_en_q    <= 1'b0;
            par_chk_en_q  <= 1'b0;
            stp_chk_en_q  <= 1'b0;
            data_valid_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q      <= 1'b0;
            par_err_mem_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            dat_samp_en_q <= dat_samp_en_d;
            strt_chk_en_q <= strt_chk_en_d;
            deser_en_q    <= deser_en_d;
            par_chk_en_q  <= par_chk_en_d;
            stp_chk_en_q  <= stp_chk_en_d;
            data_valid_q  <= data_valid_d;
`ifdef UART_RX_PARITY_EN
            par_en_q      <= par_en_d;
            par_err_mem_q <= par_err_mem_d;
`endif
        end
    end

    assign dat_samp_en = dat_samp_en_q;
    assign strt_chk_en = strt_chk_en_q;
    assign deser_en    = deser_en_q;
    assign par_chk_en  = par_chk_en_q;
    assign stp_chk_en  = stp_chk_en_q;
    assign data_valid  = data_valid_q;

endmodule
`default_nettype wire

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of data bits per frame (LSB first).
REQ-002 Parameter: CNT_W, 6, width of edge counter (supports prescale up to 32).
REQ-003 Port: clk  in  1  single receive clock (oversampling clock); one clock; reset is asynchronous and active-low.
REQ-004 Port: rst  in  1  asynchronous active-low reset.
REQ-005 Port: rx_in  in  1  serial line, idle high.
REQ-006 Port: prescale  in  6  oversampling ratio; legal 8, 16, 32.
REQ-007 Port: par_en  in  1  parity bit present in frame.
REQ-008 Port: par_typ  in  1  0 = even, 1 = odd (forwarded to parity checker, not used internally).
REQ-009 Port: strt_glitch, par_err, stp_err  in  1 each  registered checker results.
REQ-010 Port: dat_samp_en  out  1  enables the three-sample data sampler.
REQ-011 Port: strt_chk_en, deser_en, par_chk_en, stp_chk_en  out  1 each  one-cycle checker/deserializer strobes.
REQ-012 Port: data_valid  out  1  one-cycle pulse, received byte good.
REQ-013 Port: edge_cnt  out  CNT_W; bit_cnt  out  4  current counter values for the sampler.

Function
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP, DONE.
REQ-015 prescale SHALL be latched on IDLE->START; an illegal value SHALL be treated as 8; mid-frame changes SHALL be ignored.
REQ-016 edge_cnt SHALL count 0..P-1 per bit, wrap to 0 and increment bit_cnt; both SHALL hold at 0 in IDLE.
REQ-017 dat_samp_en SHALL be high in every state except IDLE and DONE.
REQ-018 IDLE->START SHALL occur on the first cycle rx_in is sampled low.
REQ-019 Each check/deser strobe SHALL pulse for one cycle at edge_cnt == P-2 of its bit: strt_chk_en in START, deser_en in each DATA bit, par_chk_en in PARITY, stp_chk_en in STOP.
REQ-020 Error inputs SHALL be evaluated at edge_cnt == P-1 of the same bit (one cycle after the strobe).
REQ-021 START: strt_glitch = 1 at evaluation -> IDLE; else -> DATA at bit end.
REQ-022 DATA -> PARITY after DATA_WIDTH bits if par_en latched 1, else -> STOP.
REQ-023 PARITY -> STOP at bit end regardless of par_err; par_err SHALL be remembered for the frame.
REQ-024 STOP -> DONE at bit end; DONE lasts exactly one cycle.
REQ-025 In DONE, data_valid SHALL pulse iff stp_err == 0 and the remembered par_err == 0.
REQ-026 DONE -> START if rx_in == 0 (back-to-back frame, counters restarted at 0), else -> IDLE.
REQ-027 par_en SHALL be latched with prescale; later changes SHALL not affect the current frame.

Reset
REQ-028 On rst low: state IDLE, edge_cnt 0, bit_cnt 0, all strobe outputs and data_valid 0, latched prescale 8, latched par_en 0, par_err memory 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no data_valid pulse; first frame after deassertion SHALL decode normally.

Configuration
REQ-030 Macro UART_RX_PARITY_EN: defined -> PARITY state, par_chk_en and par_err handling present per REQ-022/023/025.
REQ-031 Without UART_RX_PARITY_EN: par_en and par_err ignored, par_chk_en tied 0, DATA always -> STOP, ports retained.

Structure
REQ-032 Package uart_rx_pkg SHALL hold the state enum, the legal prescale constants (8/16/32) and the default DATA_WIDTH.
REQ-033 Sub-module edge_bit_counter SHALL implement edge_cnt/bit_cnt under an enable and clear from the FSM.

Verification
REQ-034 P=8, par_en=0, frame 0x55 with stop=1 -> deser_en pulses 8 times, data_valid one pulse exactly 10*8 cycles after start edge.
REQ-035 P=16, par_en=1, par_err forced 1 -> traverses PARITY, stp_chk_en pulses, no data_valid, returns to IDLE.
REQ-036 Start low for 3 cycles then high, strt_glitch=1 -> START->IDLE, no deser_en pulse.
REQ-037 Two back-to-back frames, P=32, no idle gap -> DONE->START, two data_valid pulses.
REQ-038 prescale=12 -> behaves as 8; prescale changed 16->8 mid-frame -> frame timing stays 16.
REQ-039 rst low in DATA bit 4 -> all outputs 0 next cycle, no data_valid; following frame decodes correctly.
